// File: rtl/magnitude_estimator_pipe_pkg.sv
// agc_mag_pkg: shared mode encodings and parameter sanity helper for the
// AGC envelope estimator (magnitude_estimator_pipe / mag_lane).
package agc_mag_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_L1   = 2'b00;  // mx + mn
    localparam mode_t MODE_HALF = 2'b01;  // mx + mn/2
    localparam mode_t MODE_3_8  = 2'b10;  // mx + 3/8*mn
    localparam mode_t MODE_MAX  = 2'b11;  // mx

    // The L1 sum of two W_IN-bit magnitudes needs one extra bit.
    function automatic bit widths_ok(input int w_in, input int w_out);
        return w_out >= w_in + 1;
    endfunction

endpackage

// File: rtl/magnitude_estimator_pipe_lane.sv
// mag_lane: one I/Q channel of the envelope estimator.
//   S1 |a|,|b|  ->  S2 max/min  ->  S3 mode combine (Output lane)
//   plus the per-lane block accumulator driven by shared control from the top.
// Ports:
//   clk, rst          clock, async active-high reset
//   in_a, in_b        signed I/Q sample
//   vld_in            input valid (loads S1)
//   vld_s1, vld_s2    stage valids (load S2, S3)
//   vld_out           Output valid (accumulate enable)
//   mode              mode carried alongside the S2 data
//   restart           Clear or mode change: start a new averaging block
//   wrap              this Output completes the block
//   mag               per-lane envelope estimate
//   avg               per-lane block mean
module mag_lane
    import agc_mag_pkg::*;
#(
    parameter int W_IN     = 26,
    parameter int W_OUT    = 27,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_IN-1:0]   in_a,
    input  logic [W_IN-1:0]   in_b,
    input  logic              vld_in,
    input  logic              vld_s1,
    input  logic              vld_s2,
    input  logic              vld_out,
    input  mode_t             mode,
    input  logic              restart,
    input  logic              wrap,
    output logic [W_OUT-1:0]  mag,
    output logic [W_OUT-1:0]  avg
);

    logic [W_IN-1:0]  abs_a, abs_b, mx, mn;
    logic [W_OUT-1:0] mx_e, mn_e, comb;

    // Unsigned W_IN-bit negate: -2^(W_IN-1) maps to 2^(W_IN-1) exactly.
    function automatic logic [W_IN-1:0] abs_w(input logic [W_IN-1:0] x);
        return x[W_IN-1] ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        mx_e = W_OUT'(mx);
        mn_e = W_OUT'(mn);
        case (mode)
            MODE_L1:   comb = mx_e + mn_e;
            MODE_HALF: comb = mx_e + (mn_e >> 1);
            MODE_3_8:  comb = mx_e + (mn_e >> 2) + (mn_e >> 3);
            default:   comb = mx_e;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_a <= '0;
            abs_b <= '0;
            mx    <= '0;
            mn    <= '0;
            mag   <= '0;
        end else begin
            if (vld_in) begin
                abs_a <= abs_w(in_a);
                abs_b <= abs_w(in_b);
            end
            if (vld_s1) begin
                mx <= (abs_a > abs_b) ? abs_a : abs_b;
                mn <= (abs_a > abs_b) ? abs_b : abs_a;
            end
            if (vld_s2)
                mag <= comb;
        end
    end

    generate
        if (LOG2_AVG > 0) begin : g_avg
            localparam int AW = W_OUT + LOG2_AVG;
            logic [AW-1:0]    acc, sum;
            logic [W_OUT-1:0] avg_r;

            assign sum = acc + AW'(mag);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc   <= '0;
                    avg_r <= '0;
                end else if (restart) begin
                    // a sample arriving with the restart opens the new block
                    acc <= vld_out ? AW'(mag) : '0;
                end else if (vld_out) begin
                    if (wrap) begin
                        avg_r <= W_OUT'(sum >> LOG2_AVG);
                        acc   <= '0;
                    end else begin
                        acc <= sum;
                    end
                end
            end
            assign avg = avg_r;
        end else begin : g_bypass
            assign avg = mag;
        end
    endgenerate

endmodule

// File: rtl/magnitude_estimator_pipe.sv
// magnitude_estimator_pipe: multi-channel I/Q envelope estimator, 3-stage
// valid-tagged pipeline with optional 2^LOG2_AVG block averager.
// Ports:
//   clk, rst            clock, async active-high reset
//   Mode                00 mx+mn, 01 mx+mn/2, 10 mx+3/8mn, 11 mx
//   Clear               synchronous restart of the averaging block
//   Valid               Input_a/Input_b valid
//   Input_a, Input_b    N_CH packed signed samples
//   Valid_out_module    Output valid, Valid delayed 3 cycles
//   Output              N_CH packed unsigned envelopes
//   Valid_avg           one-cycle pulse, Output_avg updated
//   Output_avg          N_CH packed block means
module magnitude_estimator_pipe
    import agc_mag_pkg::*;
#(
    parameter int W_IN     = 26,
    parameter int W_OUT    = 27,
    parameter int N_CH     = 1,
    parameter int LOG2_AVG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              Mode,
    input  logic                    Clear,
    input  logic                    Valid,
    input  logic [N_CH*W_IN-1:0]    Input_a,
    input  logic [N_CH*W_IN-1:0]    Input_b,
    output logic                    Valid_out_module,
    output logic [N_CH*W_OUT-1:0]   Output,
    output logic                    Valid_avg,
    output logic [N_CH*W_OUT-1:0]   Output_avg
);

    generate
        if (!widths_ok(W_IN, W_OUT)) begin : g_bad_width
            $error("W_OUT must be at least W_IN+1");
        end
    endgenerate

    // vld_pipe[k] = data valid at the output of stage k; stage 0 is Valid itself.
    logic [3:1] vld_pipe;
    mode_t      mode_s2;    // mode travelling with the S2 data
    mode_t      mode_s3;    // mode of the sample currently on Output
    logic       mode_chg;   // Output carries a different mode than the one before
    logic       restart, wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            mode_s2  <= MODE_L1;
            mode_s3  <= MODE_L1;
            mode_chg <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], Valid};
            if (vld_pipe[1])
                mode_s2 <= Mode;
            mode_chg <= 1'b0;
            if (vld_pipe[2]) begin
                mode_s3  <= mode_s2;
                mode_chg <= (mode_s2 != mode_s3);
            end
        end
    end

    assign Valid_out_module = vld_pipe[3];
    assign restart          = Clear | mode_chg;

    generate
        if (LOG2_AVG > 0) begin : g_cnt
            localparam int CW = LOG2_AVG;
            logic [CW-1:0] cnt;
            logic          vavg;

            assign wrap = Valid_out_module && (cnt == CW'((1 << LOG2_AVG) - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt  <= '0;
                    vavg <= 1'b0;
                end else begin
                    vavg <= 1'b0;
                    if (restart)
                        cnt <= Valid_out_module ? CW'(1) : '0;
                    else if (Valid_out_module) begin
                        cnt  <= wrap ? '0 : cnt + CW'(1);
                        vavg <= wrap;
                    end
                end
            end
            assign Valid_avg = vavg;
        end else begin : g_nocnt
            assign wrap      = 1'b0;
            assign Valid_avg = Valid_out_module;
        end
    endgenerate

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            mag_lane #(
                .W_IN     (W_IN),
                .W_OUT    (W_OUT),
                .LOG2_AVG (LOG2_AVG)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .in_a    (Input_a[k*W_IN +: W_IN]),
                .in_b    (Input_b[k*W_IN +: W_IN]),
                .vld_in  (Valid),
                .vld_s1  (vld_pipe[1]),
                .vld_s2  (vld_pipe[2]),
                .vld_out (vld_pipe[3]),
                .mode    (mode_s2),
                .restart (restart),
                .wrap    (wrap),
                .mag     (Output[k*W_OUT +: W_OUT]),
                .avg     (Output_avg[k*W_OUT +: W_OUT])
            );
        end
    endgenerate

endmodule
